// File: rtl/lc3b_types.sv
// Shared LC-3b types for the fetch stage: word type, fetch FSM states and
// the IF/ID pipeline register payload.
package lc3b_types;

    localparam int LC3B_WORD_W = 16;

    typedef logic [LC3B_WORD_W-1:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        SQUASH = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic     valid;
        lc3b_word ir;
        lc3b_word pc;
        lc3b_word npc;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a full entry, or just drops the valid bit
// when flushed. Flush wins so a wrong-path entry can never be latched.
module if_id_reg
    import lc3b_types::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_load,
    input  logic   i_flush,
    input  if_id_t i_d,
    output if_id_t o_q
);

    if_id_t r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_flush) begin
            r_q.valid <= 1'b0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// LC-3b fetch stage: owns the PC, the I-cache read handshake and IF/ID.
// Redirects never move the address of an in-flight read; SQUASH absorbs it.
module fetch_stage
    import lc3b_types::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             icache_read,
    output logic [WIDTH-1:0] icache_address,
    input  logic             icache_resp,
    input  logic [WIDTH-1:0] icache_rdata,
    input  logic             decode_ready,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_ir,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_npc,
    output logic             icache_stall_int
);

    fetch_state_t r_state, w_nstate;
    lc3b_word     r_pc, w_npc;
    lc3b_word     r_target, w_ntarget;
    lc3b_word     r_buf_ir, r_buf_pc;
    lc3b_word     w_pc_inc, w_rpc;
    logic         w_free, w_ld, w_flush, w_buf_ld;
    if_id_t       w_d, w_q;

    assign w_pc_inc = r_pc + lc3b_word'(2);
    assign w_rpc    = redirect_pc & ~lc3b_word'(1);
    assign w_free   = decode_ready | ~w_q.valid;

    always_comb begin
        w_nstate  = r_state;
        w_npc     = r_pc;
        w_ntarget = r_target;
        w_ld      = 1'b0;
        w_flush   = 1'b0;
        w_buf_ld  = 1'b0;
        w_d       = '0;
        case (r_state)
            IDLE: begin
                w_nstate = FETCH;
                if (redirect_valid) w_npc = w_rpc;
            end
            FETCH: begin
                if (redirect_valid) begin
                    w_flush = 1'b1;
                    if (icache_resp) begin
                        w_npc = w_rpc;
                    end else begin
                        w_ntarget = w_rpc;
                        w_nstate  = SQUASH;
                    end
                end else if (icache_resp) begin
                    w_npc = w_pc_inc;
                    if (w_free) begin
                        w_ld = 1'b1;
                        w_d  = '{valid: 1'b1, ir: icache_rdata, pc: r_pc, npc: w_pc_inc};
                    end else begin
                        w_buf_ld = 1'b1;
                        w_nstate = HOLD;
                    end
                end else if (decode_ready) begin
                    w_flush = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    w_flush  = 1'b1;
                    w_npc    = w_rpc;
                    w_nstate = FETCH;
                end else if (decode_ready) begin
                    w_ld     = 1'b1;
                    w_d      = '{valid: 1'b1, ir: r_buf_ir, pc: r_buf_pc,
                                 npc: r_buf_pc + lc3b_word'(2)};
                    w_nstate = FETCH;
                end
            end
            SQUASH: begin
                // The in-flight rdata is always discarded; only the target moves.
                if (redirect_valid) begin
                    w_flush   = 1'b1;
                    w_ntarget = w_rpc;
                    if (icache_resp) begin
                        w_npc    = w_rpc;
                        w_nstate = FETCH;
                    end
                end else if (icache_resp) begin
                    w_npc    = r_target;
                    w_nstate = FETCH;
                end
            end
            default: w_nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_pc     <= RESET_PC;
            r_target <= '0;
            r_buf_ir <= '0;
            r_buf_pc <= '0;
        end else begin
            r_state  <= w_nstate;
            r_pc     <= w_npc;
            r_target <= w_ntarget;
            if (w_buf_ld) begin
                r_buf_ir <= icache_rdata;
                r_buf_pc <= r_pc;
            end
        end
    end

    if_id_reg u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_ld),
        .i_flush (w_flush),
        .i_d     (w_d),
        .o_q     (w_q)
    );

    assign icache_read      = (r_state == FETCH) || (r_state == SQUASH);
    assign icache_address   = r_pc;
    assign icache_stall_int = icache_read & ~icache_resp;
    assign if_valid         = w_q.valid;
    assign if_ir            = w_q.ir;
    assign if_pc            = w_q.pc;
    assign if_npc           = w_q.npc;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan steps followed by a random phase,
// all checked against an in-order instruction-stream model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icache_read;
    logic [15:0] icache_address;
    logic        icache_resp;
    logic [15:0] icache_rdata;
    logic        decode_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic [15:0] if_ir, if_pc, if_npc;
    logic        icache_stall_int;

    always #5 clk = ~clk;

    fetch_stage #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .icache_read      (icache_read),
        .icache_address   (icache_address),
        .icache_resp      (icache_resp),
        .icache_rdata     (icache_rdata),
        .decode_ready     (decode_ready),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .if_valid         (if_valid),
        .if_ir            (if_ir),
        .if_pc            (if_pc),
        .if_npc           (if_npc),
        .icache_stall_int (icache_stall_int)
    );

    int tests = 0;
    int fails = 0;

    // Program-order model: the next instruction decode should accept.
    logic [15:0] exp_next;
    bit          prev_wait, prev_redir;
    logic [15:0] prev_addr;
    // I-cache responder state.
    bit          pend, miss_en, rand_lat, force_resp;
    int          wcnt, miss_lat;
    logic [15:0] miss_addr;
    // Observations from the most recent cycle.
    bit          last_stall, last_resp;
    logic [15:0] last_addr;

    function automatic logic [15:0] mem(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_next   = 16'h0000;
        prev_wait  = 1'b0;
        prev_redir = 1'b0;
        pend       = 1'b0;
    endtask

    // Called just after a negedge: drive one cycle, check it, advance.
    task automatic cyc(input bit rdy, input bit rv, input logic [15:0] rpc);
        decode_ready   = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        icache_resp    = 1'b0;
        icache_rdata   = 16'($urandom);
        if (icache_read) begin
            if (!pend) begin
                pend = 1'b1;
                if (miss_en && icache_address == miss_addr) wcnt = miss_lat;
                else if (rand_lat) wcnt = $urandom_range(0, 3);
                else wcnt = 0;
            end
            if (wcnt == 0) begin
                icache_resp  = 1'b1;
                icache_rdata = mem(icache_address);
                pend         = 1'b0;
            end else begin
                wcnt--;
            end
        end else begin
            pend = 1'b0;
        end
        if (force_resp) begin
            icache_resp  = 1'b1;
            icache_rdata = 16'hDEAD;
        end
        #1;
        chk("stall_int", 16'(icache_stall_int), 16'(icache_read & ~icache_resp));
        chk("addr_align", 16'(icache_address[0]), 16'h0);
        if (prev_wait) begin
            chk("read_held", 16'(icache_read), 16'h1);
            chk("addr_held", icache_address, prev_addr);
        end
        if (prev_redir) chk("valid_after_redirect", 16'(if_valid), 16'h0);
        if (if_valid) chk("npc", if_npc, if_pc + 16'd2);
        if (rv) begin
            exp_next = rpc & 16'hFFFE;
        end else if (if_valid && rdy) begin
            chk("seq_pc", if_pc, exp_next);
            chk("seq_ir", if_ir, mem(if_pc));
            exp_next = if_pc + 16'd2;
        end
        prev_wait  = icache_read & ~icache_resp;
        prev_addr  = icache_address;
        prev_redir = rv;
        last_stall = icache_stall_int;
        last_resp  = icache_resp;
        last_addr  = icache_address;
        @(negedge clk);
    endtask

    initial begin
        int  n, sc;
        bit  got;
        rst_n = 1'b0; icache_resp = 1'b0; icache_rdata = '0;
        decode_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        miss_en = 1'b0; rand_lat = 1'b0; force_resp = 1'b0;
        miss_addr = '0; miss_lat = 0; wcnt = 0;
        model_reset();

        // Reset state.
        @(negedge clk); #1;
        chk("rst_read", 16'(icache_read), 16'h0);
        chk("rst_valid", 16'(if_valid), 16'h0);
        chk("rst_pc", if_pc, 16'h0);
        chk("rst_ir", if_ir, 16'h0);
        chk("rst_addr", icache_address, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        chk("idle_read", 16'(icache_read), 16'h0);
        cyc(1, 0, 0);

        // Back-to-back hits from RESET_PC.
        chk("bb_addr0", icache_address, 16'h0000);
        chk("bb_valid0", 16'(if_valid), 16'h0);
        cyc(1, 0, 0);
        chk("bb_addr1", icache_address, 16'h0002);
        chk("bb_valid1", 16'(if_valid), 16'h1);
        chk("bb_pc1", if_pc, 16'h0000);
        cyc(1, 0, 0);
        chk("bb_addr2", icache_address, 16'h0004);
        chk("bb_pc2", if_pc, 16'h0002);

        // Five-cycle miss at 0x0010.
        miss_en = 1'b1; miss_addr = 16'h0010; miss_lat = 5;
        n = 0;
        while (icache_address != 16'h0010 && n < 40) begin cyc(1, 0, 0); n++; end
        sc = 0; got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            cyc(1, 0, 0);
            chk("miss_addr", last_addr, 16'h0010);
            if (last_stall) sc++;
            if (last_resp) got = 1'b1;
        end
        chk("miss_resp_seen", 16'(got), 16'h1);
        chk("miss_stall_cycles", 16'(sc), 16'd5);
        chk("miss_if_pc", if_pc, 16'h0010);
        chk("miss_if_valid", 16'(if_valid), 16'h1);

        // Backpressure at 0x0020.
        n = 0;
        while (icache_address != 16'h0020 && n < 40) begin cyc(1, 0, 0); n++; end
        chk("bp_valid_pre", 16'(if_valid), 16'h1);
        cyc(0, 0, 0);
        chk("bp_hold_read", 16'(icache_read), 16'h0);
        chk("bp_hold_pc", if_pc, 16'h001E);
        cyc(0, 0, 0);
        chk("bp_hold_read2", 16'(icache_read), 16'h0);
        cyc(1, 0, 0);
        chk("bp_if_pc", if_pc, 16'h0020);
        chk("bp_if_valid", 16'(if_valid), 16'h1);
        chk("bp_resume_addr", icache_address, 16'h0022);
        chk("bp_resume_read", 16'(icache_read), 16'h1);

        // Redirect while 0x0030 is outstanding.
        miss_addr = 16'h0030; miss_lat = 3;
        n = 0;
        while (icache_address != 16'h0030 && n < 40) begin cyc(1, 0, 0); n++; end
        cyc(1, 1, 16'h4000);
        chk("sq_valid", 16'(if_valid), 16'h0);
        chk("sq_addr", icache_address, 16'h0030);
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            cyc(1, 0, 0);
            chk("sq_addr_hold", last_addr, 16'h0030);
            chk("sq_valid_hold", 16'(if_valid), 16'h0);
            if (last_resp) got = 1'b1;
        end
        chk("sq_resp_seen", 16'(got), 16'h1);
        chk("sq_next_addr", icache_address, 16'h4000);
        chk("sq_next_valid", 16'(if_valid), 16'h0);

        // Redirect coincident with resp, then two redirects in SQUASH.
        miss_addr = 16'h7000; miss_lat = 4;
        cyc(1, 1, 16'h7000);
        chk("co_addr", icache_address, 16'h7000);
        chk("co_valid", 16'(if_valid), 16'h0);
        cyc(1, 1, 16'h4000);
        chk("dbl_addr1", icache_address, 16'h7000);
        cyc(1, 1, 16'h5001);
        chk("dbl_addr2", icache_address, 16'h7000);
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            cyc(1, 0, 0);
            chk("dbl_valid_hold", 16'(if_valid), 16'h0);
            if (last_resp) got = 1'b1;
        end
        chk("dbl_next_addr", icache_address, 16'h5000);
        chk("dbl_next_valid", 16'(if_valid), 16'h0);
        cyc(1, 0, 0);
        chk("dbl_if_pc", if_pc, 16'h5000);
        chk("dbl_if_ir", if_ir, mem(16'h5000));

        // Wrap at 0xFFFE.
        cyc(1, 1, 16'hFFFE);
        chk("wrap_addr0", icache_address, 16'hFFFE);
        cyc(1, 0, 0);
        chk("wrap_addr1", icache_address, 16'h0000);
        chk("wrap_if_pc", if_pc, 16'hFFFE);
        chk("wrap_if_npc", if_npc, 16'h0000);

        // Reset in the middle of a miss with a valid IF/ID entry.
        miss_addr = 16'h0002; miss_lat = 10;
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("mr_valid_pre", 16'(if_valid), 16'h1);
        chk("mr_read_pre", 16'(icache_read), 16'h1);
        icache_resp = 1'b0; redirect_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mr_read", 16'(icache_read), 16'h0);
        chk("mr_valid", 16'(if_valid), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        miss_en = 1'b0;
        chk("mr_idle_read", 16'(icache_read), 16'h0);
        force_resp = 1'b1;
        cyc(1, 0, 0);
        force_resp = 1'b0;
        chk("mr_restart_addr", icache_address, 16'h0000);
        chk("mr_restart_read", 16'(icache_read), 16'h1);
        chk("mr_late_resp_valid", 16'(if_valid), 16'h0);
        cyc(1, 0, 0);
        chk("mr_first_pc", if_pc, 16'h0000);
        chk("mr_first_ir", if_ir, mem(16'h0000));

        // Random traffic: latency, backpressure and redirects.
        rand_lat = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
